// File: rtl/fdd_port_if.sv
// rtl/fdd_port_if.sv - CPU register-window bus for the floppy drive port
interface fdd_port_if;
  logic       sel;
  logic       wr;
  logic       rd;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output sel, output wr, output rd, output addr, output din, input dout);
  modport slave  (input sel, input wr, input rd, input addr, input din, output dout);
endinterface

// File: rtl/fdd_port.sv
// rtl/fdd_port.sv - floppy drive select/side/motor port with CPU hold toward the FDC
// Define FDD_PORT_TIMEOUT_EN to bound cpu_hold by HOLD_TIMEOUT ce pulses with a sticky status flag.
module fdd_port #(
  parameter int DRIVES       = 2,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int MOTOR_TIME   = 4000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  fdd_port_if.slave         bus,
  input  logic              fdc_drq,
  input  logic              fdc_busy,
  input  logic [DRIVES-1:0] drive_rdy,
  output logic              cpu_hold,
  output logic [1:0]        drive,
  output logic              side,
  output logic              ready,
  output logic              motor_on
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int MW = (MOTOR_TIME > 1) ? $clog2(MOTOR_TIME + 1) : 1;

  state_t        state, state_nx;
  logic          we, we_q, wr_evt, cmd_evt, release_c;
  logic          timeout, timeout_flag;
  logic [MW-1:0] motor_cnt;
  logic [3:0]    rdy_all;

  assign we        = bus.wr & bus.sel;
  assign wr_evt    = we & ~we_q;
  assign cmd_evt   = wr_evt & (bus.addr == 2'd0);
  assign release_c = fdc_drq | ~fdc_busy;

`ifdef FDD_PORT_TIMEOUT_EN
  localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  logic [HW-1:0] hold_cnt;
  logic          stat_rd, stat_rd_q;
  logic          din_unused;

  assign stat_rd    = bus.rd & bus.sel & (bus.addr == 2'd1);
  assign din_unused = ^bus.din[7:2];

  // A fresh addr-0 command restarts the window instead of expiring it.
  assign timeout = (state == HOLD) & ce & ~cmd_evt & ((int'(hold_cnt) + 1) == HOLD_TIMEOUT);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if ((state == HOLD) && (state_nx == HOLD)) begin
      if (cmd_evt)
        hold_cnt <= '0;
      else if (ce)
        hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stat_rd_q    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      stat_rd_q <= stat_rd;
      if (timeout)
        timeout_flag <= 1'b1;
      else if (stat_rd_q && !stat_rd)
        timeout_flag <= 1'b0;
    end
  end
`else
  logic cfg_unused;

  assign timeout      = 1'b0;
  assign timeout_flag = 1'b0;
  assign cfg_unused   = (HOLD_TIMEOUT == 0) ^ bus.rd ^ (^bus.din[7:2]);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_evt && fdc_busy && !fdc_drq) state_nx = HOLD;
      HOLD:    if (release_c || timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      we_q  <= 1'b0;
    end else begin
      state <= state_nx;
      we_q  <= we;
    end
  end

  assign cpu_hold = (state == HOLD);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      drive <= 2'd0;
      side  <= 1'b0;
    end else if (wr_evt) begin
      if (bus.addr == 2'd2)
        side <= bus.din[0];
      else if ((bus.addr == 2'd3) && (int'(bus.din[1:0]) < DRIVES))
        drive <= bus.din[1:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      motor_cnt <= '0;
    else if (wr_evt || (state == HOLD))
      motor_cnt <= MW'(MOTOR_TIME);
    else if (ce && (motor_cnt != '0))
      motor_cnt <= motor_cnt - 1'b1;
  end

  assign motor_on = (motor_cnt != '0);

  // drive never exceeds DRIVES-1, so padding keeps the index in range for any DRIVES.
  assign rdy_all = 4'(drive_rdy);
  assign ready   = rdy_all[drive];

  always_comb begin
    bus.dout = 8'hFF;
    if (bus.sel && (bus.addr == 2'd1))
      bus.dout = {timeout_flag, motor_on, cpu_hold, side, ready, 1'b0, drive};
  end

endmodule

// File: tb/tb_fdd_port.sv
// tb/tb_fdd_port.sv - directed and randomized checks of fdd_port against a behavioural model
module tb_fdd_port;
  localparam int DRIVES  = 2;
  localparam int HOLD_TO = 10;
  localparam int MOTOR_T = 5;

  logic       clk_sys = 1'b0;
  logic       reset, ce, fdc_drq, fdc_busy;
  logic [1:0] drive_rdy;
  logic       cpu_hold, side, ready, motor_on;
  logic [1:0] drive;

  int n_checks = 0;
  int n_fail   = 0;

  fdd_port_if bus();

  fdd_port #(.DRIVES(DRIVES), .HOLD_TIMEOUT(HOLD_TO), .MOTOR_TIME(MOTOR_T)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .bus(bus),
    .fdc_drq(fdc_drq), .fdc_busy(fdc_busy), .drive_rdy(drive_rdy),
    .cpu_hold(cpu_hold), .drive(drive), .side(side), .ready(ready), .motor_on(motor_on)
  );

  always #5 clk_sys = ~clk_sys;

  // Behavioural model: port state as plain variables, advanced once per clock.
  bit         m_hold, m_flag, m_side, m_we_prev, m_rd_prev;
  int         m_hold_ce, m_motor;
  logic [1:0] m_drive;

  function automatic void model_step();
    bit we, evt, rd_now, expired;
    we      = bus.wr && bus.sel;
    evt     = we && !m_we_prev;
    rd_now  = bus.rd && bus.sel && (bus.addr == 2'd1);
    expired = 0;
    if (reset) begin
      m_hold = 0; m_flag = 0; m_side = 0; m_we_prev = 0; m_rd_prev = 0;
      m_hold_ce = 0; m_motor = 0; m_drive = 2'd0;
      return;
    end
    if (evt || m_hold) m_motor = MOTOR_T;
    else if (ce && m_motor > 0) m_motor = m_motor - 1;
    if (m_hold) begin
`ifdef FDD_PORT_TIMEOUT_EN
      if (evt && bus.addr == 2'd0) m_hold_ce = 0;
      else if (ce) begin
        m_hold_ce = m_hold_ce + 1;
        if (m_hold_ce == HOLD_TO) expired = 1;
      end
`endif
      if (fdc_drq || !fdc_busy || expired) begin
        m_hold = 0;
        m_hold_ce = 0;
      end
    end else if (evt && bus.addr == 2'd0 && fdc_busy && !fdc_drq) begin
      m_hold = 1;
      m_hold_ce = 0;
    end
`ifdef FDD_PORT_TIMEOUT_EN
    if (expired) m_flag = 1;
    else if (m_rd_prev && !rd_now) m_flag = 0;
`endif
    if (evt && bus.addr == 2'd2) m_side = bus.din[0];
    if (evt && bus.addr == 2'd3 && int'(bus.din[1:0]) < DRIVES) m_drive = bus.din[1:0];
    m_we_prev = we;
    m_rd_prev = rd_now;
  endfunction

  function automatic logic [13:0] model_out();
    logic       rdy;
    logic [7:0] d;
    rdy = drive_rdy[m_drive];
    d   = (bus.sel && bus.addr == 2'd1) ?
          {m_flag, (m_motor != 0), m_hold, m_side, rdy, 1'b0, m_drive} : 8'hFF;
    return {d, m_hold, m_drive, m_side, rdy, (m_motor != 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    bus.sel = 1; bus.wr = 1; bus.addr = a; bus.din = d;
    tick();
    bus.wr = 0; bus.sel = 0;
    tick();
  endtask

  initial begin
    reset = 1; ce = 0; fdc_drq = 0; fdc_busy = 0; drive_rdy = 2'b00;
    bus.sel = 0; bus.wr = 0; bus.rd = 0; bus.addr = 2'd0; bus.din = 8'h00;
    tick();
    tick();
    check("reset_hold", cpu_hold, 1'b0);
    check("reset_drive", drive, 2'd0);
    check("reset_motor", motor_on, 1'b0);
    check("dout_unselected", bus.dout, 8'hFF);
    bus.sel = 1; bus.addr = 2'd1; #1;
    check("reset_status", bus.dout, 8'h00);
    bus.addr = 2'd2; #1;
    check("dout_other_addr", bus.dout, 8'hFF);
    bus.sel = 0;
    reset = 0;
    tick();

    fdc_busy = 1; fdc_drq = 0;
    wr_reg(2'd0, 8'h00);
    check("hold_enter", cpu_hold, 1'b1);
    fdc_drq = 1;
    tick();
    check("hold_release_drq", cpu_hold, 1'b0);
    fdc_drq = 0;

    fdc_busy = 0;
    wr_reg(2'd0, 8'h00);
    check("no_hold_idle", cpu_hold, 1'b0);
    fdc_busy = 1; fdc_drq = 1;
    wr_reg(2'd0, 8'h00);
    check("no_hold_drq", cpu_hold, 1'b0);
    fdc_drq = 0;

    drive_rdy = 2'b10;
    wr_reg(2'd3, 8'h01);
    wr_reg(2'd2, 8'h01);
    check("drive_sel", drive, 2'd1);
    check("ready_sel", ready, 1'b1);
    check("side_sel", side, 1'b1);
    bus.sel = 1; bus.addr = 2'd1; #1;
    check("status_drive", bus.dout, 8'h59);
    bus.sel = 0;
    wr_reg(2'd3, 8'h03);
    check("drive_out_of_range", drive, 2'd1);

    wr_reg(2'd0, 8'h00);
    check("hold_for_timeout", cpu_hold, 1'b1);
    ce = 1;
    repeat (HOLD_TO - 1) tick();
    check("hold_before_limit", cpu_hold, 1'b1);
    tick();
    ce = 0;
`ifdef FDD_PORT_TIMEOUT_EN
    check("timeout_release", cpu_hold, 1'b0);
    bus.sel = 1; bus.rd = 1; bus.addr = 2'd1; #1;
    check("status_timeout", bus.dout, 8'hD9);
    tick();
    bus.rd = 0; bus.sel = 0;
    tick();
    bus.sel = 1; #1;
    check("flag_cleared", bus.dout[7], 1'b0);
    check("status_after_read", bus.dout, 8'h59);
    bus.sel = 0;
`else
    check("hold_no_timeout", cpu_hold, 1'b1);
    bus.sel = 1; bus.addr = 2'd1; #1;
    check("status_no_flag", bus.dout, 8'h79);
    bus.sel = 0;
    fdc_drq = 1;
    tick();
    fdc_drq = 0;
    check("hold_drq_exit", cpu_hold, 1'b0);
`endif

    drive_rdy = 2'b00;
    wr_reg(2'd0, 8'h00);
    check("hold_before_reset", cpu_hold, 1'b1);
    reset = 1;
    tick();
    reset = 0;
    check("reset_mid_hold", cpu_hold, 1'b0);
    bus.sel = 1; bus.addr = 2'd1; #1;
    check("status_after_reset", bus.dout, 8'h00);
    bus.sel = 0;

    wr_reg(2'd2, 8'h00);
    check("motor_loaded", motor_on, 1'b1);
    ce = 1;
    repeat (MOTOR_T - 1) tick();
    check("motor_still_on", motor_on, 1'b1);
    tick();
    check("motor_expired", motor_on, 1'b0);
    ce = 0;

    bus.sel = 1; bus.wr = 1; bus.addr = 2'd3; bus.din = 8'h00;
    tick();
    bus.din = 8'h01;
    tick();
    tick();
    check("one_event_per_strobe", drive, 2'd0);
    bus.wr = 0; bus.sel = 0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      ce        = $urandom_range(0, 1);
      bus.sel   = ($urandom_range(0, 3) != 0);
      bus.wr    = ($urandom_range(0, 2) == 0);
      bus.rd    = ($urandom_range(0, 2) == 0);
      bus.addr  = 2'($urandom_range(0, 3));
      bus.din   = 8'($urandom);
      fdc_busy  = ($urandom_range(0, 4) != 0);
      fdc_drq   = ($urandom_range(0, 5) == 0);
      drive_rdy = 2'($urandom_range(0, 3));
      tick();
      check("random_outputs",
            {bus.dout, cpu_hold, drive, side, ready, motor_on}, model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
